// File: rtl/ccd_hreadout.sv
// ccd_hreadout -- CCD horizontal-register readout sequencer.
//
// One accepted `start` reads one line of `line_len` pixels. Each pixel walks
// through RG -> REF -> XFER -> SIG -> ADC, each sub-step PHASE_TICKS clocks
// long, driving the H1..H4 phases and the reset-gate / CDS / ADC strobes.
// The ADC word is captured at the end of ADC and handed to a one-entry
// valid/ready holding register. The CCD timing never waits for the consumer:
// a pixel that finds the holding register still occupied is dropped and the
// sticky `overrun` flag is raised.
//
// Optional feature, macro CCD_HREADOUT_DIGITAL_CDS_EN:
//   the ADC word is also latched at the end of REF, and the delivered pixel
//   becomes (signal - reference), floored at zero. Analog strobes are the same.
//   Without the macro the raw ADC word is delivered and no reference register
//   exists.

module ccd_hreadout #(
  parameter int PHASE_TICKS = 4,
  parameter int PIXEL_W     = 12,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   line_len,
  output logic               busy,
  output logic               done,
  input  logic [PIXEL_W-1:0] ccd_adc,
  output logic [3:0]         ccd_horizontal_phases,
  output logic               ccd_rg,
  output logic               ccd_cds_1,
  output logic               ccd_cds_2,
  output logic               ccd_adc_sample,
  output logic [PIXEL_W-1:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               overrun
);

  // Tick counter must hold 0..PHASE_TICKS-1; keep at least one bit.
  localparam int                TICK_W    = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RG   = 3'd1;
  localparam logic [2:0] ST_REF  = 3'd2;
  localparam logic [2:0] ST_XFER = 3'd3;
  localparam logic [2:0] ST_SIG  = 3'd4;
  localparam logic [2:0] ST_ADC  = 3'd5;
  localparam logic [2:0] ST_FIN  = 3'd6;

  // H1..H4 patterns: parked, transfer, signal, convert.
  localparam logic [3:0] H_PARK = 4'b0011;
  localparam logic [3:0] H_XFER = 4'b0110;
  localparam logic [3:0] H_SIG  = 4'b1100;
  localparam logic [3:0] H_ADC  = 4'b1001;

  // Pin image for a state: {h[3:0], rg, cds_1, cds_2, adc_sample}.
  function automatic logic [7:0] pins_for(input logic [2:0] st);
    logic [7:0] p;
    case (st)
      ST_RG:   p = {H_PARK, 4'b1000};
      ST_REF:  p = {H_PARK, 4'b0100};
      ST_XFER: p = {H_XFER, 4'b0000};
      ST_SIG:  p = {H_SIG,  4'b0010};
      ST_ADC:  p = {H_ADC,  4'b0001};
      default: p = {H_PARK, 4'b0000};
    endcase
    return p;
  endfunction

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic [TICK_W-1:0]  tick_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   len_r;
  logic               last_tick_s;
  logic               timed_s;
  logic               start_ok_s;
  logic               line_end_s;
  logic               cap_s;
  logic [7:0]         pins_nxt_s;
  logic [PIXEL_W-1:0] pixel_s;
  logic [PIXEL_W-1:0] cap_data_r;
  logic               cap_pend_r;

  assign last_tick_s = (tick_r == TICK_LAST);
  assign timed_s     = (state_r >= ST_RG) && (state_r <= ST_ADC);
  // A start in the cycle that shows `done` belongs to the line just finished.
  assign start_ok_s  = start && (state_r == ST_IDLE) && !done;
  // Compare one bit wider so a maximal line_len cannot wrap the count.
  assign line_end_s  = (({1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, len_r});
  assign cap_s       = (state_r == ST_ADC) && last_tick_s;
  assign pins_nxt_s  = pins_for(state_nxt_s);

  // Next-state decode for the per-pixel sub-step sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if (line_len == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = ST_RG;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RG: begin
        if (last_tick_s) state_nxt_s = ST_REF;
        else             state_nxt_s = ST_RG;
      end
      ST_REF: begin
        if (last_tick_s) state_nxt_s = ST_XFER;
        else             state_nxt_s = ST_REF;
      end
      ST_XFER: begin
        if (last_tick_s) state_nxt_s = ST_SIG;
        else             state_nxt_s = ST_XFER;
      end
      ST_SIG: begin
        if (last_tick_s) state_nxt_s = ST_ADC;
        else             state_nxt_s = ST_SIG;
      end
      ST_ADC: begin
        if (last_tick_s) begin
          if (line_end_s) state_nxt_s = ST_FIN;
          else            state_nxt_s = ST_RG;
        end else begin
          state_nxt_s = ST_ADC;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Sub-step tick counter: restarts on every state change, idle outside RG..ADC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= {TICK_W{1'b0}};
    end else if (timed_s && (state_nxt_s == state_r)) begin
      tick_r <= tick_r + TICK_W'(1);
    end else begin
      tick_r <= {TICK_W{1'b0}};
    end
  end

  // Line length latch and pixel counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r <= {CNT_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      len_r <= line_len;
      cnt_r <= {CNT_W{1'b0}};
    end else if (cap_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Registered pin drive and status, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccd_horizontal_phases <= H_PARK;
      ccd_rg                <= 1'b0;
      ccd_cds_1             <= 1'b0;
      ccd_cds_2             <= 1'b0;
      ccd_adc_sample        <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      ccd_horizontal_phases <= pins_nxt_s[7:4];
      ccd_rg                <= pins_nxt_s[3];
      ccd_cds_1             <= pins_nxt_s[2];
      ccd_cds_2             <= pins_nxt_s[1];
      ccd_adc_sample        <= pins_nxt_s[0];
      busy                  <= (state_nxt_s != ST_IDLE);
      done                  <= (state_r == ST_FIN);
    end
  end

`ifdef CCD_HREADOUT_DIGITAL_CDS_EN
  logic [PIXEL_W-1:0] ref_r;
  logic [PIXEL_W:0]   diff_s;

  // Reference level latched on the last clock of REF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_r <= {PIXEL_W{1'b0}};
    end else if ((state_r == ST_REF) && last_tick_s) begin
      ref_r <= ccd_adc;
    end
  end

  // Digital CDS: signal minus reference, negative results floored at zero.
  always_comb begin
    diff_s = {1'b0, ccd_adc} - {1'b0, ref_r};
    if (diff_s[PIXEL_W]) begin
      pixel_s = {PIXEL_W{1'b0}};
    end else begin
      pixel_s = diff_s[PIXEL_W-1:0];
    end
  end
`else
  // Raw ADC word is the pixel.
  always_comb begin
    pixel_s = ccd_adc;
  end
`endif

  // Capture stage: pixel registered on the last clock of ADC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data_r <= {PIXEL_W{1'b0}};
      cap_pend_r <= 1'b0;
    end else begin
      cap_pend_r <= cap_s;
      if (cap_s) begin
        cap_data_r <= pixel_s;
      end
    end
  end

  // One-entry holding register; a busy slot keeps its pixel and drops the new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_data  <= {PIXEL_W{1'b0}};
      pix_valid <= 1'b0;
    end else if (cap_pend_r) begin
      if (pix_valid && !pix_ready) begin
        pix_valid <= 1'b1;
      end else begin
        pix_data  <= cap_data_r;
        pix_valid <= 1'b1;
      end
    end else if (pix_valid && pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

  // Sticky overrun: set on a dropped pixel, cleared by reset or an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (start_ok_s) begin
      overrun <= 1'b0;
    end else if (cap_pend_r && pix_valid && !pix_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccd_hreadout.sv
// tb_ccd_hreadout -- directed, table-driven bench for ccd_hreadout with
// PHASE_TICKS=2 (pixel period 10 clocks). Inputs change and outputs are
// observed on the falling clock edge. Expected pixels depend on whether
// CCD_HREADOUT_DIGITAL_CDS_EN is defined.

module tb_ccd_hreadout;

  localparam int PT = 2;
  localparam int PW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] line_len;
  logic          busy;
  logic          done;
  logic [PW-1:0] ccd_adc;
  logic [3:0]    ccd_horizontal_phases;
  logic          ccd_rg;
  logic          ccd_cds_1;
  logic          ccd_cds_2;
  logic          ccd_adc_sample;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          overrun;

  ccd_hreadout #(.PHASE_TICKS(PT), .PIXEL_W(PW), .CNT_W(CW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .line_len              (line_len),
    .busy                  (busy),
    .done                  (done),
    .ccd_adc               (ccd_adc),
    .ccd_horizontal_phases (ccd_horizontal_phases),
    .ccd_rg                (ccd_rg),
    .ccd_cds_1             (ccd_cds_1),
    .ccd_cds_2             (ccd_cds_2),
    .ccd_adc_sample        (ccd_adc_sample),
    .pix_data              (pix_data),
    .pix_valid             (pix_valid),
    .pix_ready             (pix_ready),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] obs_pins;
  assign obs_pins = {ccd_horizontal_phases, ccd_rg, ccd_cds_1, ccd_cds_2, ccd_adc_sample};

  int tests = 0;
  int fails = 0;

  // ADC stimulus for the current line, indexed by pixel.
  logic [PW-1:0] cur_ref [4];
  logic [PW-1:0] cur_sig [4];
  int            adc_idx = -1;
  logic          prev_rg = 1'b0;

  typedef struct {
    int               len;
    logic [3:0][11:0] refv;
    logic [3:0][11:0] sigv;
    logic [3:0][11:0] exp_raw;
    logic [3:0][11:0] exp_cds;
  } line_vec_t;

  line_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected pin image for PHASE_TICKS=2, cyc counted from the clock after start.
  function automatic logic [7:0] exp_pins(input int cyc, input int len);
    int ph;
    if (cyc >= 1 && cyc <= 10 * len) begin
      ph = ((cyc - 1) % 10) / 2;
      case (ph)
        0:       return {4'b0011, 4'b1000};
        1:       return {4'b0011, 4'b0100};
        2:       return {4'b0110, 4'b0000};
        3:       return {4'b1100, 4'b0010};
        4:       return {4'b1001, 4'b0001};
        default: return {4'b0011, 4'b0000};
      endcase
    end
    return {4'b0011, 4'b0000};
  endfunction

  function automatic logic [11:0] exp_pix(input int v, input int k);
`ifdef CCD_HREADOUT_DIGITAL_CDS_EN
    return vecs[v].exp_cds[k];
`else
    return vecs[v].exp_raw[k];
`endif
  endfunction

  // Advance to the next falling edge and present the ADC level for the pixel in progress.
  task automatic tick();
    @(negedge clk);
    if (ccd_rg && !prev_rg) adc_idx++;
    prev_rg = ccd_rg;
    if (adc_idx >= 0 && adc_idx < 4) begin
      if (ccd_rg)                                ccd_adc = cur_ref[adc_idx];
      else if (ccd_horizontal_phases == 4'b0110) ccd_adc = cur_sig[adc_idx];
    end
  endtask

  task automatic run_line(input int v);
    int L;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int npix;
    int pin_bad;
    L = vecs[v].len;
    busy_cnt = 0; done_cnt = 0; done_at = -1; npix = 0; pin_bad = 0;
    for (int i = 0; i < 4; i++) begin
      cur_ref[i] = vecs[v].refv[i];
      cur_sig[i] = vecs[v].sigv[i];
    end
    adc_idx   = -1;
    pix_ready = 1'b1;
    line_len  = CW'(L);
    start     = 1'b1;
    for (int cyc = 1; cyc <= 10 * L + 6; cyc++) begin
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (obs_pins !== exp_pins(cyc, L)) pin_bad++;
      if (pix_valid && pix_ready) begin
        if (npix < 4) begin
          check($sformatf("vec%0d pix%0d data", v, npix), 32'(pix_data), 32'(exp_pix(v, npix)));
          check($sformatf("vec%0d pix%0d cycle", v, npix), cyc, 10 * npix + 12);
        end
        npix++;
      end
    end
    check($sformatf("vec%0d pixel count", v), npix, L);
    check($sformatf("vec%0d busy cycles", v), busy_cnt, 10 * L + 1);
    check($sformatf("vec%0d done pulses", v), done_cnt, 1);
    check($sformatf("vec%0d done cycle", v), done_at, 10 * L + 2);
    check($sformatf("vec%0d pin sequence errors", v), pin_bad, 0);
    check($sformatf("vec%0d overrun", v), 32'(overrun), 32'd0);
  endtask

  // Give up after a fixed time so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cnt;
    bit seen;

    rst = 1'b1; start = 1'b0; line_len = '0; ccd_adc = '0; pix_ready = 1'b0;

    // line vectors: {len, ref[3..0], sig[3..0], raw expected, cds expected}
    vecs[0] = '{3, {12'h000, 12'h000, 12'h000, 12'h000}, {12'h000, 12'h300, 12'h200, 12'h100},
                   {12'h000, 12'h300, 12'h200, 12'h100}, {12'h000, 12'h300, 12'h200, 12'h100}};
    vecs[1] = '{1, {12'h000, 12'h000, 12'h000, 12'h050}, {12'h000, 12'h000, 12'h000, 12'h3A0},
                   {12'h000, 12'h000, 12'h000, 12'h3A0}, {12'h000, 12'h000, 12'h000, 12'h350}};
    vecs[2] = '{1, {12'h000, 12'h000, 12'h000, 12'h400}, {12'h000, 12'h000, 12'h000, 12'h100},
                   {12'h000, 12'h000, 12'h000, 12'h100}, {12'h000, 12'h000, 12'h000, 12'h000}};
    vecs[3] = '{2, {12'h000, 12'h000, 12'hFFF, 12'h010}, {12'h000, 12'h000, 12'hFFF, 12'hFFF},
                   {12'h000, 12'h000, 12'hFFF, 12'hFFF}, {12'h000, 12'h000, 12'h000, 12'hFEF}};
    vecs[4] = '{0, {12'h000, 12'h000, 12'h000, 12'h000}, {12'h000, 12'h000, 12'h000, 12'h000},
                   {12'h000, 12'h000, 12'h000, 12'h000}, {12'h000, 12'h000, 12'h000, 12'h000}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset h",         32'(ccd_horizontal_phases), 32'h3);
    check("reset strobes",   32'(obs_pins[3:0]), 32'h0);
    check("reset busy",      32'(busy), 32'h0);
    check("reset done",      32'(done), 32'h0);
    check("reset pix_valid", 32'(pix_valid), 32'h0);
    check("reset pix_data",  32'(pix_data), 32'h0);
    check("reset overrun",   32'(overrun), 32'h0);
    rst = 1'b0;

    // Idle hold for 20 clocks.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({obs_pins, busy, done, pix_valid, overrun} !== {8'h30, 4'h0}) bad++;
    end
    check("idle hold errors", bad, 0);

    // Table-driven lines with a ready consumer.
    for (int v = 0; v < 5; v++) begin
      tick();
      run_line(v);
    end

    // Overrun: four pixels, consumer never ready.
    cur_ref[0] = 12'h000; cur_ref[1] = 12'h000; cur_ref[2] = 12'h000; cur_ref[3] = 12'h000;
    cur_sig[0] = 12'h111; cur_sig[1] = 12'h222; cur_sig[2] = 12'h333; cur_sig[3] = 12'h444;
    adc_idx = -1; pix_ready = 1'b0; line_len = 16'd4; start = 1'b1;
    for (int cyc = 1; cyc <= 46; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 12) begin
        check("ovr first valid", 32'(pix_valid), 32'h1);
        check("ovr first data",  32'(pix_data), 32'h111);
      end
      if (cyc == 21) check("ovr before drop", 32'(overrun), 32'h0);
      if (cyc == 22) check("ovr after drop",  32'(overrun), 32'h1);
    end
    check("ovr held valid", 32'(pix_valid), 32'h1);
    check("ovr held data",  32'(pix_data), 32'h111);
    check("ovr sticky",     32'(overrun), 32'h1);
    pix_ready = 1'b1;
    tick();
    check("ovr drain valid",  32'(pix_valid), 32'h0);
    check("ovr still sticky", 32'(overrun), 32'h1);

    // Next start clears overrun; a start coinciding with done is ignored.
    cur_sig[0] = 12'h0AB; adc_idx = -1; line_len = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ovr cleared by start", 32'(overrun), 32'h0);
    check("busy after start",     32'(busy), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("done seen", 32'(seen), 32'h1);
    start = 1'b1; line_len = 16'd1;
    tick();
    start = 1'b0;
    check("start on done ignored", 32'(busy), 32'h0);
    repeat (3) tick();

    // Start while busy is ignored; asynchronous reset during SIG aborts the line.
    cur_sig[0] = 12'h155; cur_sig[1] = 12'h166; adc_idx = -1;
    line_len = 16'd2; start = 1'b1;
    tick(); start = 1'b0;                       // cyc 1
    tick(); start = 1'b1; line_len = 16'd0;     // cyc 2
    tick(); start = 1'b0;                       // cyc 3
    check("busy start ignored, REF", 32'(obs_pins), 32'h34);
    tick(); tick();                             // cyc 5
    check("busy start ignored, XFER", 32'(obs_pins), 32'h60);
    tick(); tick();                             // cyc 7
    check("in SIG before reset", 32'(obs_pins), 32'hC2);
    #2 rst = 1'b1;
    #1;
    check("async rst h",         32'(ccd_horizontal_phases), 32'h3);
    check("async rst strobes",   32'(obs_pins[3:0]), 32'h0);
    check("async rst busy",      32'(busy), 32'h0);
    check("async rst pix_data",  32'(pix_data), 32'h0);
    check("async rst pix_valid", 32'(pix_valid), 32'h0);
    tick(); tick();
    rst = 1'b0;
    cnt = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) cnt++;
      if ({obs_pins, busy} !== {8'h30, 1'b0}) bad++;
    end
    check("no done after reset", cnt, 0);
    check("idle after reset errors", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
